// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared sizing defaults for the stream FIFO and its users
// Provides default beat width, depth and flag thresholds, plus cnt_width()
// so wrappers and benches size count ports the same way as the FIFO.
package fifo_stream_pkg;
    localparam int DEF_DATA_WIDTH   = 128;
    localparam int DEF_DEPTH        = 512;
    localparam int DEF_ALMOST_FULL  = 496;
    localparam int DEF_ALMOST_EMPTY = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fifo_stream_bram.sv
// bram_sdp: simple dual-port RAM with one write port and a registered read port
// Ports: clk; we/waddr/wdata write a word; re/raddr read a word, rdata valid
// one cycle after re.
module bram_sdp
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEF_DEPTH),
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_stream.sv
// fifo_stream: FWFT valid/ready FIFO, BRAM storage plus a 2-entry output skid stage
// Ports: clk, reset_n (async, active-low), flush (sync clear);
// s_data/s_valid/s_ready push side; m_data/m_valid/m_ready pop side;
// count (beats held), full, empty, almost_full, almost_empty (all registered).
module fifo_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ALMOST_FULL  = DEF_ALMOST_FULL,
    parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = cnt_width(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [CNT_WIDTH-1:0]  ram_count, ram_count_n, cnt_n;
    logic [1:0]            occ, occ_p, occ_n;
    logic                  inflight, rdy_r, push, pop, re;
    logic [DATA_WIDTH-1:0] skid0, skid1, s0_n, s1_n, rdata;

    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
        return p == ADDR_WIDTH'(DEPTH - 1) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // rdy_r mirrors !full but stays low in reset, so s_ready rises on the first edge after release
    assign s_ready = rdy_r & ~flush;
    assign m_valid = occ != 2'd0;
    assign m_data  = skid0;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // ram_count is the registered value, so a beat written this cycle is never read back in the same cycle
    assign re          = ~flush & (ram_count != '0) & ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2);
    assign cnt_n       = flush ? '0 : count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    assign ram_count_n = flush ? '0 : ram_count + CNT_WIDTH'(push) - CNT_WIDTH'(re);

    // Pop shifts the skid down; returning RAM data lands in the first free slot after the shift
    assign occ_p = occ - 2'(pop);
    assign occ_n = flush ? 2'd0 : occ_p + 2'(inflight);
    assign s0_n  = (inflight && occ_p == 2'd0) ? rdata : pop ? skid1 : skid0;
    assign s1_n  = (inflight && occ_p != 2'd0) ? rdata : skid1;

    bram_sdp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wptr),
        .wdata(s_data),
        .re   (re),
        .raddr(rptr),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr         <= '0;
            rptr         <= '0;
            ram_count    <= '0;
            count        <= '0;
            occ          <= 2'd0;
            inflight     <= 1'b0;
            skid0        <= '0;
            skid1        <= '0;
            rdy_r        <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wptr         <= flush ? '0 : push ? inc(wptr) : wptr;
            rptr         <= flush ? '0 : re ? inc(rptr) : rptr;
            ram_count    <= ram_count_n;
            count        <= cnt_n;
            occ          <= occ_n;
            inflight     <= re;
            skid0        <= s0_n;
            skid1        <= s1_n;
            rdy_r        <= cnt_n != CNT_WIDTH'(DEPTH);
            full         <= cnt_n == CNT_WIDTH'(DEPTH);
            empty        <= cnt_n == '0;
            almost_full  <= cnt_n >= CNT_WIDTH'(ALMOST_FULL);
            almost_empty <= cnt_n <= CNT_WIDTH'(ALMOST_EMPTY);
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (count > CNT_WIDTH'(DEPTH) || occ > 2'd2) $finish;
    end
`endif
endmodule

// File: tb/tb_fifo_stream.sv
// tb_fifo_stream: scoreboard bench for fifo_stream at DEPTH=512 and DEPTH=5
module tb_fifo_stream;
    import fifo_stream_pkg::*;
    localparam int DW = 128;
    localparam int BD = 512;
    localparam int SD = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          b_flush = 0, b_sv = 0, b_mr = 0, b_sr, b_mv, b_full, b_empty, b_af, b_ae;
    logic [DW-1:0] b_sd = '0, b_md;
    logic [cnt_width(BD)-1:0] b_cnt;
    logic          s_flush = 0, s_sv = 0, s_mr = 0, s_sr, s_mv, s_full, s_empty, s_af, s_ae;
    logic [DW-1:0] s_sd = '0, s_md;
    logic [cnt_width(SD)-1:0] s_cnt;

    int total = 0;
    int bad = 0;
    int b_pops = 0;
    logic [DW-1:0] bq[$], sq[$];
    logic [DW-1:0] be, se;

    fifo_stream #(.DATA_WIDTH(DW), .DEPTH(BD), .ALMOST_FULL(496), .ALMOST_EMPTY(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .s_data(b_sd), .s_valid(b_sv), .s_ready(b_sr),
        .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr),
        .count(b_cnt), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae)
    );

    fifo_stream #(.DATA_WIDTH(DW), .DEPTH(SD), .ALMOST_FULL(4), .ALMOST_EMPTY(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .flush(s_flush),
        .s_data(s_sd), .s_valid(s_sv), .s_ready(s_sr),
        .m_data(s_md), .m_valid(s_mv), .m_ready(s_mr),
        .count(s_cnt), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae)
    );

    // Scoreboard: handshakes sampled mid-cycle; pop compared before this cycle's push is queued
    always @(negedge clk) begin
        if (!reset_n) begin
            bq.delete();
            sq.delete();
        end else begin
            if (b_mv && b_mr) begin
                b_pops++;
                total++;
                if (bq.size() == 0) begin
                    bad++;
                    $display("FAIL b_pop_unexpected got=%h want=none", b_md);
                end else begin
                    be = bq.pop_front();
                    if (b_md !== be) begin
                        bad++;
                        $display("FAIL b_order got=%h want=%h", b_md, be);
                    end
                end
            end
            if (b_sv && b_sr) bq.push_back(b_sd);
            if (b_flush) bq.delete();
            if (s_mv && s_mr) begin
                total++;
                if (sq.size() == 0) begin
                    bad++;
                    $display("FAIL s_pop_unexpected got=%h want=none", s_md);
                end else begin
                    se = sq.pop_front();
                    if (s_md !== se) begin
                        bad++;
                        $display("FAIL s_order got=%h want=%h", s_md, se);
                    end
                end
            end
            if (s_sv && s_sr) sq.push_back(s_sd);
            if (s_flush) sq.delete();
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if ({b_sr, b_mv, b_full, b_empty, b_af, b_ae} !== 6'b000101 || b_cnt !== '0 || b_md !== '0) begin
            bad++;
            $display("FAIL b_in_reset got=%b cnt=%0d data=%h want=000101 cnt=0 data=0",
                     {b_sr, b_mv, b_full, b_empty, b_af, b_ae}, b_cnt, b_md);
        end
        total++;
        if ({s_sr, s_mv, s_full, s_empty, s_af, s_ae} !== 6'b000101 || s_cnt !== '0) begin
            bad++;
            $display("FAIL s_in_reset got=%b cnt=%0d want=000101 cnt=0",
                     {s_sr, s_mv, s_full, s_empty, s_af, s_ae}, s_cnt);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (b_sr !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b want=0", b_sr);
        end
        tick();
        total++;
        if ({b_sr, s_sr, b_mv, b_empty, b_ae} !== 5'b11011 || b_cnt !== '0) begin
            bad++;
            $display("FAIL after_release got=%b cnt=%0d want=11011 cnt=0",
                     {b_sr, s_sr, b_mv, b_empty, b_ae}, b_cnt);
        end
    endtask

    task automatic test_latency;
        b_sd = {16{8'hA5}};
        b_sv = 1;
        b_mr = 1;
        tick();
        b_sv = 0;
        total++;
        if (b_cnt !== 10'd1 || b_mv !== 1'b0) begin
            bad++;
            $display("FAIL lat_t got cnt=%0d mv=%b want cnt=1 mv=0", b_cnt, b_mv);
        end
        tick();
        total++;
        if (b_mv !== 1'b0) begin
            bad++;
            $display("FAIL lat_t1 got mv=%b want 0", b_mv);
        end
        tick();
        total++;
        if (b_mv !== 1'b1 || b_md !== {16{8'hA5}} || b_cnt !== 10'd1) begin
            bad++;
            $display("FAIL lat_t2 got mv=%b data=%h cnt=%0d want mv=1 data=a5.. cnt=1", b_mv, b_md, b_cnt);
        end
        tick();
        b_mr = 0;
        total++;
        if (b_cnt !== 10'd0 || b_empty !== 1'b1 || b_mv !== 1'b0) begin
            bad++;
            $display("FAIL lat_drained got cnt=%0d empty=%b mv=%b want 0 1 0", b_cnt, b_empty, b_mv);
        end
    endtask

    task automatic drain_small(input string tag);
        s_mr = 1;
        for (int k = 0; k < 20 && !s_empty; k++) tick();
        s_mr = 0;
        total++;
        if (s_empty !== 1'b1 || s_cnt !== '0 || s_mv !== 1'b0 || sq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got empty=%b cnt=%0d mv=%b left=%0d want 1 0 0 0",
                     tag, s_empty, s_cnt, s_mv, sq.size());
        end
    endtask

    task automatic test_fill_drain;
        for (int r = 0; r < 3; r++) begin
            s_mr = 0;
            for (int i = 1; i <= SD; i++) begin
                s_sd = DW'(r * 16 + i);
                s_sv = 1;
                tick();
                total++;
                if (s_cnt !== 3'(i) || s_af !== (i >= 4) || s_ae !== (i <= 1)) begin
                    bad++;
                    $display("FAIL fill_flags r=%0d i=%0d got cnt=%0d af=%b ae=%b", r, i, s_cnt, s_af, s_ae);
                end
            end
            s_sd = DW'(8'hEE);
            total++;
            if (s_full !== 1'b1 || s_sr !== 1'b0) begin
                bad++;
                $display("FAIL fill_full got full=%b ready=%b want 1 0", s_full, s_sr);
            end
            tick();
            s_sv = 0;
            total++;
            if (s_cnt !== 3'd5) begin
                bad++;
                $display("FAIL push_when_full got cnt=%0d want 5", s_cnt);
            end
            drain_small("fill");
        end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < SD; i++) begin
            s_sd = DW'(12'h100 + i);
            s_sv = 1;
            tick();
        end
        s_sd = DW'(12'h1FF);
        s_mr = 1;
        #1;
        total++;
        if (s_sr !== 1'b0 || s_mv !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_pre got ready=%b mv=%b want 0 1", s_sr, s_mv);
        end
        tick();
        s_mr = 0;
        total++;
        if (s_cnt !== 3'd4 || s_sr !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_after got cnt=%0d ready=%b want 4 1", s_cnt, s_sr);
        end
        tick();
        s_sv = 0;
        total++;
        if (s_cnt !== 3'd5 || s_full !== 1'b1) begin
            bad++;
            $display("FAIL full_refill got cnt=%0d full=%b want 5 1", s_cnt, s_full);
        end
        drain_small("full_pop");
    endtask

    task automatic test_concurrent;
        int sent = 0;
        int wc = 0;
        int gaps = 0;
        int maxc = 0;
        int p0 = b_pops;
        logic win;
        for (int c = 0; c < 20000 && sent < 2000; c++) begin
            win = (sent >= 500 && wc < 1000);
            b_sv = win || ($urandom_range(0, 1) == 1);
            b_mr = win || ($urandom_range(0, 1) == 1);
            b_sd = DW'(32'h1000_0000 + sent);
            @(negedge clk);
            if (b_sv && b_sr) sent++;
            if (win) begin
                wc++;
                if (wc > 4 && !b_mv) gaps++;
            end
            if (int'(b_cnt) > maxc) maxc = int'(b_cnt);
            @(posedge clk);
            #1;
        end
        b_sv = 0;
        b_mr = 1;
        for (int k = 0; k < 2000 && !b_empty; k++) tick();
        b_mr = 0;
        total++;
        if (sent != 2000 || wc != 1000) begin
            bad++;
            $display("FAIL conc_budget got sent=%0d window=%0d want 2000 1000", sent, wc);
        end
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL conc_gaps got %0d want 0", gaps);
        end
        total++;
        if (maxc > BD) begin
            bad++;
            $display("FAIL conc_maxcount got %0d want <=%0d", maxc, BD);
        end
        total++;
        if (b_pops - p0 != 2000 || bq.size() != 0 || b_empty !== 1'b1) begin
            bad++;
            $display("FAIL conc_delivered got %0d left=%0d empty=%b want 2000 0 1", b_pops - p0, bq.size(), b_empty);
        end
    endtask

    task automatic queue_ten(input logic [DW-1:0] base);
        b_mr = 0;
        for (int i = 0; i < 10; i++) begin
            b_sd = base + DW'(i);
            b_sv = 1;
            tick();
        end
        b_sv = 0;
        repeat (3) tick();
        b_mr = 1;
        tick();
        b_mr = 0;
    endtask

    task automatic push_77(input string tag);
        b_sd = DW'(8'h77);
        b_sv = 1;
        tick();
        b_sv = 0;
        b_mr = 1;
        for (int k = 0; k < 10 && !b_mv; k++) tick();
        total++;
        if (b_mv !== 1'b1 || b_md !== DW'(8'h77)) begin
            bad++;
            $display("FAIL %s_first got mv=%b data=%h want 1 77", tag, b_mv, b_md);
        end
        tick();
        b_mr = 0;
        total++;
        if (b_empty !== 1'b1 || bq.size() != 0) begin
            bad++;
            $display("FAIL %s_end got empty=%b left=%0d want 1 0", tag, b_empty, bq.size());
        end
    endtask

    task automatic test_flush;
        queue_ten(DW'(12'h200));
        b_flush = 1;
        b_sv = 1;
        b_sd = DW'(8'h55);
        #1;
        total++;
        if (b_sr !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready got %b want 0", b_sr);
        end
        tick();
        b_flush = 0;
        b_sv = 0;
        total++;
        if (b_cnt !== '0 || b_mv !== 1'b0 || b_empty !== 1'b1) begin
            bad++;
            $display("FAIL flush_clear got cnt=%0d mv=%b empty=%b want 0 0 1", b_cnt, b_mv, b_empty);
        end
        tick();
        total++;
        if (b_mv !== 1'b0 || b_cnt !== '0) begin
            bad++;
            $display("FAIL flush_stale got mv=%b cnt=%0d want 0 0", b_mv, b_cnt);
        end
        push_77("flush");
    endtask

    task automatic test_reset_mid;
        queue_ten(DW'(12'h300));
        b_sv = 1;
        b_sd = DW'(8'h66);
        #1 reset_n = 1'b0;
        #6 reset_n = 1'b1;
        b_sv = 0;
        total++;
        if (b_cnt !== '0 || b_mv !== 1'b0 || b_empty !== 1'b1 || b_sr !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_clear got cnt=%0d mv=%b empty=%b ready=%b want 0 0 1 0",
                     b_cnt, b_mv, b_empty, b_sr);
        end
        tick();
        total++;
        if (b_sr !== 1'b1 || b_mv !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ready got ready=%b mv=%b want 1 0", b_sr, b_mv);
        end
        push_77("rst_mid");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_drain();
        test_full_pop();
        test_concurrent();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
